serial_paralelo_param: RTL



---
 rtl/sp_pkg.sv | 27 ++
 rtl/sp_shift_align.sv | 51 +++++
 rtl/serial_paralelo_param.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_pkg
// Description : Shared definitions for the serial-to-parallel receiver:
//               FSM state encoding, default COM/IDL symbols and a counter
//               width helper.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package sp_pkg;

    // Receiver alignment states
    localparam int unsigned  c_STATE_W = 2;
    localparam logic [1:0]   c_SEARCH  = 2'd0;
    localparam logic [1:0]   c_ALIGN   = 2'd1;
    localparam logic [1:0]   c_ACTIVE  = 2'd2;

    // Default 8-bit symbols; widened/truncated to DATA_W by the users
    localparam logic [7:0]   c_COM_SYM_DEF = 8'hBC;
    localparam logic [7:0]   c_IDL_SYM_DEF = 8'h7C;

    // Width of a counter that must hold values 0..n-1 (never below 1 bit)
    function automatic int f_cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_shift_align.sv
`default_nettype none
// ============================================================================
// Module      : sp_shift_align
// Description : Serial shift register, word bit counter and COM compare.
//               o_nxt is the candidate word including the bit being sampled
//               this cycle; o_boundary marks the last bit of an aligned word.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module sp_shift_align
    import sp_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] COM_SYM = DATA_W'(c_COM_SYM_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_data,
    input  logic              i_sync,
    output logic [DATA_W-1:0] o_nxt,
    output logic              o_boundary,
    output logic              o_com_match
);

    localparam int                 c_CNT_W = f_cnt_w(DATA_W);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DATA_W - 1);

    // Only DATA_W-1 history bits are needed: the newest bit comes from i_data
    logic [DATA_W-2:0]  r_sr;
    logic [c_CNT_W-1:0] r_bit_cnt;

    assign o_nxt       = {r_sr, i_data};
    assign o_boundary  = (r_bit_cnt == c_LAST);
    assign o_com_match = (o_nxt == COM_SYM);

    // Shift every cycle; the bit counter restarts on a sync request or wraps at the word end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr <= o_nxt[DATA_W-2:0];
            if (i_sync || o_boundary) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/serial_paralelo_param.sv
`default_nettype none
// ============================================================================
// Module      : serial_paralelo_param
// Description : Parametrised serial-to-parallel receiver. Hunts for the COM
//               symbol at any bit offset, locks after ACTIVE_COUNT aligned
//               COMs, presents non-idle words on data_out_SP/valid_SP and
//               drops lock after MISALIGN_MAX misaligned COMs.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module serial_paralelo_param
    import sp_pkg::*;
#(
    parameter int                DATA_W       = 8,
    parameter logic [DATA_W-1:0] COM_SYM      = DATA_W'(c_COM_SYM_DEF),
    parameter logic [DATA_W-1:0] IDL_SYM      = DATA_W'(c_IDL_SYM_DEF),
    parameter int                ACTIVE_COUNT = 4,
    parameter int                MISALIGN_MAX = 3
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in_SP,
    output logic [DATA_W-1:0] data_out_SP,
    output logic              valid_SP,
    output logic              active,
    output logic              com_det
);

    localparam int                 c_COM_W   = f_cnt_w(ACTIVE_COUNT + 1);
    localparam int                 c_MIS_W   = f_cnt_w(MISALIGN_MAX + 1);
    localparam logic [c_COM_W-1:0] c_COM_LIM = c_COM_W'(ACTIVE_COUNT);
    localparam logic [c_COM_W-1:0] c_COM_ONE = c_COM_W'(1);
    localparam logic [c_MIS_W-1:0] c_MIS_LIM = c_MIS_W'(MISALIGN_MAX);

    logic [DATA_W-1:0]  w_nxt;
    logic               w_boundary;
    logic               w_com_match;
    logic               w_idl_match;
    logic               w_sync;
    logic [c_COM_W-1:0] w_com_cnt_inc;
    logic [c_MIS_W-1:0] w_mis_cnt_inc;

    logic [c_STATE_W-1:0] r_state;
    logic [c_COM_W-1:0]   r_com_cnt;
    logic [c_MIS_W-1:0]   r_mis_cnt;
    logic [DATA_W-1:0]    r_data;
    logic                 r_valid;
    logic                 r_active;
    logic                 r_com_det;

    // A COM found while hunting defines the new word phase
    assign w_sync      = (r_state == c_SEARCH) && w_com_match;
    assign w_idl_match = (w_nxt == IDL_SYM);

    // Saturating increments
    assign w_com_cnt_inc = (r_com_cnt == c_COM_LIM) ? r_com_cnt : r_com_cnt + 1'b1;
    assign w_mis_cnt_inc = (r_mis_cnt == c_MIS_LIM) ? r_mis_cnt : r_mis_cnt + 1'b1;

    sp_shift_align #(
        .DATA_W  (DATA_W),
        .COM_SYM (COM_SYM)
    ) u_shift_align (
        .clk         (clk_32f),
        .rst         (reset),
        .i_data      (data_in_SP),
        .i_sync      (w_sync),
        .o_nxt       (w_nxt),
        .o_boundary  (w_boundary),
        .o_com_match (w_com_match)
    );

    // Alignment FSM and registered word outputs
    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state   <= c_SEARCH;
            r_com_cnt <= '0;
            r_mis_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_active  <= 1'b0;
            r_com_det <= 1'b0;
        end else begin
            r_com_det <= 1'b0;
            case (r_state)
                c_SEARCH: begin
                    if (w_com_match) begin
                        r_com_cnt <= c_COM_ONE;
                        r_com_det <= 1'b1;
                        if (ACTIVE_COUNT == 1) begin
                            r_state  <= c_ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= c_ALIGN;
                        end
                    end
                end
                c_ALIGN: begin
                    if (w_boundary) begin
                        if (w_com_match) begin
                            r_com_det <= 1'b1;
                            r_com_cnt <= w_com_cnt_inc;
                            if (w_com_cnt_inc == c_COM_LIM) begin
                                r_state  <= c_ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_state   <= c_SEARCH;
                            r_com_cnt <= '0;
                        end
                    end
                end
                c_ACTIVE: begin
                    if (w_boundary) begin
                        if (w_com_match) begin
                            r_com_det <= 1'b1;
                            r_valid   <= 1'b0;
                            r_mis_cnt <= '0;
                        end else if (w_idl_match) begin
                            r_valid <= 1'b0;
                        end else begin
                            r_data  <= w_nxt;
                            r_valid <= 1'b1;
                        end
                    end else if (w_com_match) begin
                        // COM seen at the wrong phase: count towards losing lock
                        if (w_mis_cnt_inc == c_MIS_LIM) begin
                            r_state   <= c_SEARCH;
                            r_active  <= 1'b0;
                            r_valid   <= 1'b0;
                            r_com_cnt <= '0;
                            r_mis_cnt <= '0;
                        end else begin
                            r_mis_cnt <= w_mis_cnt_inc;
                        end
                    end
                end
                default: begin
                    r_state <= c_SEARCH;
                end
            endcase
        end
    end

    assign data_out_SP = r_data;
    assign valid_SP    = r_valid;
    assign active      = r_active;
    assign com_det     = r_com_det;

endmodule
`default_nettype wire
